alu_exec: RTL and testbench

Single-lane ALU execution unit that consumes one issue slot of the ALU reservation station and produces that slot's result broadcast (`busy`/`tag`/`data` triple) on the common data bus. It sits between one reservation-station output port and the CDB arbiter. It:
- latches a ready instruction;
- executes it in one cycle, or 32 cycles for MUL;
- requests the CDB and broadcasts for exactly one cycle;
- holds its busy line high until the broadcast so the station keeps the slot allocated.

---
 rtl/alu_exec.sv | 185 ++++++++++++++++++
 tb/tb_alu_exec.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec
// Purpose  : Single-lane ALU execution unit between a reservation-station slot
//            and the CDB arbiter; one-cycle ops plus a 32-step shift-add MUL.
// Revision : 1.0
// ============================================================================
module alu_exec #(
   parameter int TAG_W    = 4,
   parameter int UNLOCKED = 0,
   parameter int OP_W     = 4,
   parameter int RA_W     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             in_busy,
   input  logic [OP_W-1:0]  in_op,
   input  logic [TAG_W-1:0] in_tagx,
   input  logic [TAG_W-1:0] in_tagy,
   input  logic [TAG_W-1:0] in_tagw,
   input  logic [31:0]      in_datax,
   input  logic [31:0]      in_datay,
   input  logic [RA_W-1:0]  in_target,
   input  logic             cdb_grant,
   output logic             cdb_req,
   output logic             busy_out,
   output logic [TAG_W-1:0] tag_out,
   output logic [31:0]      data_out,
   output logic [RA_W-1:0]  target_out
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MUL    = 3'd1,
      S_RESULT = 3'd2,
      S_BCAST  = 3'd3,
      S_DRAIN  = 3'd4
   } state_t;

   localparam logic [TAG_W-1:0] c_UNLOCKED = TAG_W'(UNLOCKED);

   state_t           r_state,   w_state_nxt;
   logic [TAG_W-1:0] r_tag,     w_tag_nxt;
   logic [RA_W-1:0]  r_target,  w_target_nxt;
   logic [31:0]      r_result,  w_result_nxt;
   logic [31:0]      r_mcand,   w_mcand_nxt;
   logic [31:0]      r_mplier,  w_mplier_nxt;
   logic [31:0]      r_acc,     w_acc_nxt;
   logic [4:0]       r_cnt,     w_cnt_nxt;

   logic             r_cdb_req,  w_cdb_req_nxt;
   logic             r_busy,     w_busy_nxt;
   logic [TAG_W-1:0] r_tag_out,  w_tag_out_nxt;
   logic [31:0]      r_data_out, w_data_out_nxt;
   logic [RA_W-1:0]  r_tgt_out,  w_tgt_out_nxt;

   logic             w_issue;
   logic             w_is_mul;
   logic [4:0]       w_shamt;
   logic [31:0]      w_alu;
   logic [31:0]      w_mul_step;

   assign w_issue    = in_busy && (in_tagx == c_UNLOCKED) && (in_tagy == c_UNLOCKED)
                       && (r_state == S_IDLE);
   assign w_is_mul   = (in_op == OP_W'(10));
   assign w_shamt    = in_datay[4:0];
   assign w_mul_step = r_acc + (r_mplier[0] ? r_mcand : 32'd0);

   // Reserved opcodes (and MUL, which never takes this path) fall back to ADD.
   always_comb begin
      w_alu = in_datax + in_datay;
      case (in_op)
         OP_W'(1): w_alu = in_datax - in_datay;
         OP_W'(2): w_alu = in_datax & in_datay;
         OP_W'(3): w_alu = in_datax | in_datay;
         OP_W'(4): w_alu = in_datax ^ in_datay;
         OP_W'(5): w_alu = in_datax << w_shamt;
         OP_W'(6): w_alu = in_datax >> w_shamt;
         OP_W'(7): w_alu = $signed(in_datax) >>> w_shamt;
         OP_W'(8): w_alu = {31'd0, $signed(in_datax) < $signed(in_datay)};
         OP_W'(9): w_alu = {31'd0, in_datax < in_datay};
         default:  w_alu = in_datax + in_datay;
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_tag_nxt    = r_tag;
      w_target_nxt = r_target;
      w_result_nxt = r_result;
      w_mcand_nxt  = r_mcand;
      w_mplier_nxt = r_mplier;
      w_acc_nxt    = r_acc;
      w_cnt_nxt    = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_issue) begin
               w_tag_nxt    = in_tagw;
               w_target_nxt = in_target;
               if (w_is_mul) begin
                  w_mcand_nxt  = in_datax;
                  w_mplier_nxt = in_datay;
                  w_acc_nxt    = 32'd0;
                  w_cnt_nxt    = 5'd0;
                  w_state_nxt  = S_MUL;
               end else begin
                  w_result_nxt = w_alu;
                  w_state_nxt  = S_RESULT;
               end
            end
         end
         S_MUL: begin
            w_acc_nxt    = w_mul_step;
            w_mcand_nxt  = r_mcand << 1;
            w_mplier_nxt = r_mplier >> 1;
            w_cnt_nxt    = r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
               w_result_nxt = w_mul_step;
               w_state_nxt  = S_RESULT;
            end
         end
         S_RESULT: begin
            if (cdb_grant) w_state_nxt = S_BCAST;
         end
         S_BCAST: w_state_nxt = S_DRAIN;
         S_DRAIN: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they stay fully registered.
   always_comb begin
      w_busy_nxt     = (w_state_nxt == S_MUL) || (w_state_nxt == S_RESULT);
      w_cdb_req_nxt  = (w_state_nxt == S_RESULT);
      w_tag_out_nxt  = c_UNLOCKED;
      w_data_out_nxt = 32'd0;
      w_tgt_out_nxt  = '0;
      if (w_state_nxt == S_BCAST) begin
         w_tag_out_nxt  = w_tag_nxt;
         w_data_out_nxt = w_result_nxt;
         w_tgt_out_nxt  = w_target_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_tag      <= c_UNLOCKED;
         r_target   <= '0;
         r_result   <= 32'd0;
         r_mcand    <= 32'd0;
         r_mplier   <= 32'd0;
         r_acc      <= 32'd0;
         r_cnt      <= 5'd0;
         r_cdb_req  <= 1'b0;
         r_busy     <= 1'b0;
         r_tag_out  <= c_UNLOCKED;
         r_data_out <= 32'd0;
         r_tgt_out  <= '0;
      end else if (rdy) begin
         r_state    <= w_state_nxt;
         r_tag      <= w_tag_nxt;
         r_target   <= w_target_nxt;
         r_result   <= w_result_nxt;
         r_mcand    <= w_mcand_nxt;
         r_mplier   <= w_mplier_nxt;
         r_acc      <= w_acc_nxt;
         r_cnt      <= w_cnt_nxt;
         r_cdb_req  <= w_cdb_req_nxt;
         r_busy     <= w_busy_nxt;
         r_tag_out  <= w_tag_out_nxt;
         r_data_out <= w_data_out_nxt;
         r_tgt_out  <= w_tgt_out_nxt;
      end
   end

   assign cdb_req    = r_cdb_req;
   assign busy_out   = r_busy;
   assign tag_out    = r_tag_out;
   assign data_out   = r_data_out;
   assign target_out = r_tgt_out;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec
// Purpose  : Directed plus randomized checks of alu_exec against a plain
//            arithmetic reference model and a cycle-count latency model.
// Revision : 1.0
// ============================================================================
module tb_alu_exec;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        in_busy;
   logic [3:0]  in_op;
   logic [3:0]  in_tagx, in_tagy, in_tagw;
   logic [31:0] in_datax, in_datay;
   logic [4:0]  in_target;
   logic        cdb_grant;
   logic        cdb_req;
   logic        busy_out;
   logic [3:0]  tag_out;
   logic [31:0] data_out;
   logic [4:0]  target_out;

   int n_cmp = 0;
   int n_bad = 0;

   alu_exec #(.TAG_W(4), .UNLOCKED(0), .OP_W(4), .RA_W(5)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .in_busy(in_busy), .in_op(in_op),
      .in_tagx(in_tagx), .in_tagy(in_tagy), .in_tagw(in_tagw),
      .in_datax(in_datax), .in_datay(in_datay), .in_target(in_target),
      .cdb_grant(cdb_grant), .cdb_req(cdb_req), .busy_out(busy_out),
      .tag_out(tag_out), .data_out(data_out), .target_out(target_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
      int unsigned sh;
      sh = y[4:0];
      case (op)
         4'd0:    return x + y;
         4'd1:    return x - y;
         4'd2:    return x & y;
         4'd3:    return x | y;
         4'd4:    return x ^ y;
         4'd5:    return x << sh;
         4'd6:    return x >> sh;
         4'd7:    return $signed(x) >>> sh;
         4'd8:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd9:    return (x < y) ? 32'd1 : 32'd0;
         4'd10:   return x * y;
         default: return x + y;
      endcase
   endfunction

   // Issue one instruction, hold the grant off for `stall` request cycles,
   // optionally freeze rdy for 4 cycles mid-execution, and check the broadcast.
   task automatic exec(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] tw, input logic [4:0] tg, input int stall,
                       input bit pause, input string nm);
      int          bcnt, rcnt, exp_lat;
      bit          done, leak;
      logic [31:0] exp;
      exp     = ref_alu(op, x, y);
      exp_lat = ((op == 4'd10) ? 33 : 1) + stall + (pause ? 4 : 0);
      bcnt = 0; rcnt = 0; done = 1'b0; leak = 1'b0;
      in_op = op; in_datax = x; in_datay = y; in_tagx = 4'd0; in_tagy = 4'd0;
      in_tagw = tw; in_target = tg; in_busy = 1'b1;
      cdb_grant = (stall == 0);
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (busy_out) begin
            bcnt++;
            if (cdb_req) rcnt++;
            if (tag_out !== 4'd0 || data_out !== 32'd0) leak = 1'b1;
            if (rcnt > stall) cdb_grant = 1'b1;
            if (pause && bcnt == 10) rdy = 1'b0;
            if (pause && bcnt == 14) rdy = 1'b1;
         end else if (bcnt > 0) begin
            done = 1'b1;
         end
      end
      if (!done) begin
         check({nm, "_timeout_busy"}, {31'd0, busy_out}, 32'd0);
      end else begin
         check({nm, "_data"},    data_out, exp);
         check({nm, "_tag"},     {28'd0, tag_out}, {28'd0, tw});
         check({nm, "_target"},  {27'd0, target_out}, {27'd0, tg});
         check({nm, "_req_bc"},  {31'd0, cdb_req}, 32'd0);
         check({nm, "_latency"}, bcnt, exp_lat);
         check({nm, "_reqcyc"},  rcnt, stall + 1);
         check({nm, "_leak"},    {31'd0, leak}, 32'd0);
         @(negedge clk);
         check({nm, "_drain_busy"}, {31'd0, busy_out}, 32'd0);
         check({nm, "_drain_tag"},  {28'd0, tag_out}, 32'd0);
         check({nm, "_drain_data"}, data_out, 32'd0);
         @(negedge clk);
         check({nm, "_noreissue"}, {31'd0, busy_out}, 32'd0);
      end
      in_busy   = 1'b0;
      cdb_grant = 1'b1;
      rdy       = 1'b1;
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] x, y;
      rst = 1'b0; rdy = 1'b1; in_busy = 1'b0; in_op = 4'd0;
      in_tagx = 4'd0; in_tagy = 4'd0; in_tagw = 4'd0;
      in_datax = 32'd0; in_datay = 32'd0; in_target = 5'd0; cdb_grant = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_req",    {31'd0, cdb_req}, 32'd0);
      check("rst_busy",   {31'd0, busy_out}, 32'd0);
      check("rst_tag",    {28'd0, tag_out}, 32'd0);
      check("rst_data",   data_out, 32'd0);
      check("rst_target", {27'd0, target_out}, 32'd0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", {31'd0, busy_out}, 32'd0);
      check("idle_req",  {31'd0, cdb_req}, 32'd0);

      exec(4'd0, 32'd5, 32'd7, 4'd3, 5'd9, 0, 1'b0, "add");

      // Operand x still locked by a producer: must not issue.
      in_busy = 1'b1; in_tagx = 4'd2; in_tagy = 4'd0; in_op = 4'd7;
      in_datax = 32'hFFFF_FFFF; in_datay = 32'd1; in_tagw = 4'd5; in_target = 5'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("wait_noissue", {31'd0, busy_out}, 32'd0);
      end
      exec(4'd7, 32'hFFFF_FFFF, 32'd1, 4'd5, 5'd2, 0, 1'b0, "sra");

      exec(4'd10, 32'h0001_0001, 32'h0001_0001, 4'd7, 5'd4, 0, 1'b0, "mul1");
      exec(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd8, 5'd31, 0, 1'b0, "mul2");
      exec(4'd9, 32'd1, 32'd2, 4'd9, 5'd1, 10, 1'b0, "sltu_stall");
      exec(4'd8, 32'hFFFF_FFFF, 32'd0, 4'd10, 5'd3, 10, 1'b0, "slt_stall");
      exec(4'd10, 32'h1234_5678, 32'h9ABC_DEF1, 4'd11, 5'd12, 0, 1'b1, "mul_frz");

      // MUL frozen at step 10, then reset asynchronously at step 20.
      in_op = 4'd10; in_datax = 32'd3; in_datay = 32'd5; in_tagx = 4'd0; in_tagy = 4'd0;
      in_tagw = 4'd6; in_target = 5'd7; in_busy = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      in_busy = 1'b0;
      rdy = 1'b0;
      check("frz_busy", {31'd0, busy_out}, 32'd1);
      repeat (4) @(negedge clk);
      rdy = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      check("prerst_busy", {31'd0, busy_out}, 32'd1);
      check("prerst_tag",  {28'd0, tag_out}, 32'd0);
      #1 rst = 1'b0;
      #1;
      check("arst_req",    {31'd0, cdb_req}, 32'd0);
      check("arst_busy",   {31'd0, busy_out}, 32'd0);
      check("arst_tag",    {28'd0, tag_out}, 32'd0);
      check("arst_data",   data_out, 32'd0);
      check("arst_target", {27'd0, target_out}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_idle", {31'd0, busy_out}, 32'd0);
         check("post_rst_tag",  {28'd0, tag_out}, 32'd0);
      end

      for (int i = 0; i < 24; i++) begin
         op = 4'($urandom_range(0, 15));
         x  = $urandom;
         y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         exec(op, x, y, 4'($urandom_range(1, 15)), 5'($urandom_range(0, 31)),
              int'($urandom_range(0, 3)), 1'b0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
